ocm_port_arbiter: RTL

Two-requester arbiter sharing one port of the 64-bit dual-port on-chip memory that holds the noise PDF/lookup tables.
- Requester 0: host/NIOS table loader (reads and writes).
- Requester 1: noise-sample lookup engine (reads).
- Performs round-robin arbitration with bounded burst ownership, an address range check, and response routing matched to the memory's one-cycle read latency (registered address, unregistered q).

---
 rtl/ocm_port_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ocm_port_arbiter.sv
// Two-requester arbiter for one port of the noise-table on-chip memory.
// It uses round-robin with bounded bursts, an address range check, and a one-stage response path.
module ocm_port_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 8960,
  parameter int BURST_MAX  = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                freeze,
  input  logic                req_valid_0,
  input  logic                req_write_0,
  input  logic [ADDR_W-1:0]   req_addr_0,
  input  logic [DATA_W/8-1:0] req_be_0,
  input  logic [DATA_W-1:0]   req_wdata_0,
  input  logic                req_valid_1,
  input  logic                req_write_1,
  input  logic [ADDR_W-1:0]   req_addr_1,
  input  logic [DATA_W/8-1:0] req_be_1,
  input  logic [DATA_W-1:0]   req_wdata_1,
  output logic                req_ready_0,
  output logic                req_ready_1,
  output logic                rsp_valid_0,
  output logic                rsp_valid_1,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BURST_MAX);
  localparam logic [ADDR_W:0]   LIMIT   = (ADDR_W + 1)'(DEPTH);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Arbitration state.
  // owner_q is the last granted requester.
  // beat_cnt_q counts its consecutive beats; 0 means no burst is open.
  logic             owner_q;
  logic [CNT_W-1:0] beat_cnt_q;

  // Response stage state.
  logic rsp_valid_0_q;
  logic rsp_valid_1_q;
  logic rsp_err_q;
  logic rsp_read_q;

  logic grant_any;
  logic grant_sel;
  req_t sel_req;
  logic in_range;

  // Grant decision
  always_comb begin
    logic [1:0] valid;
    logic       owner_cont;
    // NOTE: defaults first so every path assigns every signal; no latch can be inferred.
    grant_any  = 1'b0;
    grant_sel  = 1'b0;
    valid      = {req_valid_1, req_valid_0};
    owner_cont = (beat_cnt_q != '0) && (beat_cnt_q < CNT_MAX);
    if (!reset && !freeze) begin
      if (FIXED_PRIO != 0) begin
        if (valid[0]) begin
          grant_any = 1'b1;
          grant_sel = 1'b0;
        end else if (valid[1]) begin
          grant_any = 1'b1;
          grant_sel = 1'b1;
        end
      end else begin
        // The owner keeps the grant during an open burst. It also keeps it when it is alone.
        if (valid[owner_q] && (owner_cont || !valid[!owner_q])) begin
          grant_any = 1'b1;
          grant_sel = owner_q;
        end else if (valid[!owner_q]) begin
          grant_any = 1'b1;
          grant_sel = !owner_q;
        end
      end
    end
  end

  assign req_ready_0 = grant_any && !grant_sel;
  assign req_ready_1 = grant_any &&  grant_sel;

  assign sel_req  = grant_sel ? req_t'{req_write_1, req_addr_1, req_be_1, req_wdata_1}
                              : req_t'{req_write_0, req_addr_0, req_be_0, req_wdata_0};
  assign in_range = {1'b0, sel_req.addr} < LIMIT;

  // Memory port drive
  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    if (grant_any) begin
      mem_address    = sel_req.addr;
      mem_byteenable = sel_req.be;
      mem_writedata  = sel_req.wdata;
      mem_chipselect = in_range;
      mem_write      = in_range && sel_req.write;
    end
  end

  assign mem_clken = 1'b1;

  // Owner pointer and burst counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
      owner_q    <= 1'b1;
      beat_cnt_q <= '0;
    end else if (!grant_any) begin
      beat_cnt_q <= '0;
    end else if ((grant_sel == owner_q) && (beat_cnt_q != '0)) begin
      if (beat_cnt_q < CNT_MAX) begin
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
    end else begin
      owner_q    <= grant_sel;
      beat_cnt_q <= CNT_W'(1);
    end
  end

  // Response stage: one entry, loaded on every accept, so no backpressure is needed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_0_q <= 1'b0;
      rsp_valid_1_q <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_read_q    <= 1'b0;
    end else begin
      rsp_valid_0_q <= grant_any && !grant_sel;
      rsp_valid_1_q <= grant_any &&  grant_sel;
      rsp_err_q     <= grant_any && !in_range;
      rsp_read_q    <= grant_any &&  in_range && !sel_req.write;
    end
  end

  assign rsp_valid_0 = rsp_valid_0_q;
  assign rsp_valid_1 = rsp_valid_1_q;
  assign rsp_err     = rsp_err_q;
  // The memory q is unregistered, so read data is taken straight from the port in the response cycle.
  assign rsp_rdata   = rsp_read_q ? mem_readdata : '0;

endmodule
